mac_seq_ctrl: RTL and testbench

//  Sequences the mixed-precision MAC datapath (INT8/INT4/BIN) through one signed dot product per start command.

---
 rtl/quant_pkg.sv | 34 +++
 rtl/mac_operand_unpack.sv | 48 ++++
 rtl/mac_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_pkg.sv
// quant_pkg: shared types for the mixed-precision MAC sequencer.
//   prec_e       operand precision encoding (INT8 / INT4 / BIN)
//   EPB_*        elements packed per operand byte for each precision
//   seq_state_e  sequencer FSM states
//   elems_per_byte() maps a precision to its per-byte element count
package quant_pkg;

  typedef enum logic [1:0] {
    PREC_INT8 = 2'd0,
    PREC_INT4 = 2'd1,
    PREC_BIN  = 2'd2
  } prec_e;

  localparam int EPB_INT8 = 1;
  localparam int EPB_INT4 = 2;
  localparam int EPB_BIN  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_MAC  = 3'd3,
    S_DONE = 3'd4
  } seq_state_e;

  function automatic logic [3:0] elems_per_byte(input prec_e p);
    case (p)
      PREC_INT8: return 4'(EPB_INT8);
      PREC_INT4: return 4'(EPB_INT4);
      default:   return 4'(EPB_BIN);
    endcase
  endfunction

endpackage

// File: rtl/mac_operand_unpack.sv
// mac_operand_unpack: combinational selection of one element from a packed
// operand byte pair for the MAC. All outputs are 0 when en_i is low.
// Ports: en_i (MAC issue cycle), prec_i, sub_idx_i (element within byte),
//        byte_a_i/byte_b_i (packed bytes) -> a8/b8, a4/b4, ab/bb operands.
module mac_operand_unpack
  import quant_pkg::*;
(
  input  logic       en_i,
  input  prec_e      prec_i,
  input  logic [2:0] sub_idx_i,
  input  logic [7:0] byte_a_i,
  input  logic [7:0] byte_b_i,
  output logic [7:0] a8_o,
  output logic [7:0] b8_o,
  output logic [3:0] a4_o,
  output logic [3:0] b4_o,
  output logic       ab_o,
  output logic       bb_o
);

  always_comb begin
    a8_o = '0;
    b8_o = '0;
    a4_o = '0;
    b4_o = '0;
    ab_o = 1'b0;
    bb_o = 1'b0;
    if (en_i) begin
      case (prec_i)
        PREC_INT8: begin
          a8_o = byte_a_i;
          b8_o = byte_b_i;
        end
        PREC_INT4: begin
          // low nibble is element 0
          a4_o = sub_idx_i[0] ? byte_a_i[7:4] : byte_a_i[3:0];
          b4_o = sub_idx_i[0] ? byte_b_i[7:4] : byte_b_i[3:0];
        end
        default: begin
          // LSB is element 0; 1 encodes +1, 0 encodes -1 (MAC interprets)
          ab_o = byte_a_i[sub_idx_i];
          bb_o = byte_b_i[sub_idx_i];
        end
      endcase
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one signed dot product per start command through
// the MAC, fetching packed bytes from two synchronous RAMs (RD -> WAIT -> MAC).
// Ports: command side (start, prec_i, len_i, base_a_i, base_b_i, busy, done,
//        result), RAM side (mem_en, mem_*_addr, mem_*_rdata), MAC side
//        (mac_prec, mac_a8/b8/a4/b4/ab/bb, mac_prod).
// Build option MAC_SEQ_SAT_EN: saturate the accumulator to signed ACC_W bounds;
// otherwise it wraps modulo 2^ACC_W.
module mac_seq_ctrl
  import quant_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 12,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        prec_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [7:0]        mem_a_rdata,
  input  logic [7:0]        mem_b_rdata,
  output logic [1:0]        mac_prec,
  output logic [7:0]        mac_a8,
  output logic [7:0]        mac_b8,
  output logic [3:0]        mac_a4,
  output logic [3:0]        mac_b4,
  output logic              mac_ab,
  output logic              mac_bb,
  input  logic [31:0]       mac_prod
);

  seq_state_e               state_q, state_d;
  prec_e                    prec_q, prec_d;
  logic [LEN_W-1:0]         left_q, left_d;
  logic [2:0]               sub_q, sub_d;
  logic [ADDR_W-1:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [7:0]               byte_a_q, byte_a_d, byte_b_q, byte_b_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [ACC_W-1:0]         result_q, result_d;
  logic                     mac_en;
  logic [3:0]               epb;

  assign epb = elems_per_byte(prec_q);

`ifdef MAC_SEQ_SAT_EN
  // Add in a width that can never overflow, then clamp back into ACC_W.
  localparam int SUM_W = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;
  logic signed [SUM_W-1:0] sum_wide;

  always_comb begin
    sum_wide = SUM_W'(acc_q) + SUM_W'($signed(mac_prod));
    if (sum_wide > ACC_MAX)      acc_sum = ACC_MAX[ACC_W-1:0];
    else if (sum_wide < ACC_MIN) acc_sum = ACC_MIN[ACC_W-1:0];
    else                         acc_sum = sum_wide[ACC_W-1:0];
  end
`else
  assign acc_sum = acc_q + ACC_W'($signed(mac_prod));
`endif

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    left_d   = left_q;
    sub_d    = sub_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    byte_a_d = byte_a_q;
    byte_b_d = byte_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy     = 1'b0;
    done     = 1'b0;
    mem_en   = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prec_d   = (prec_i == 2'd3) ? PREC_BIN : prec_e'(prec_i);
          left_d   = len_i;
          sub_d    = '0;
          addr_a_d = base_a_i;
          addr_b_d = base_b_i;
          acc_d    = '0;
          if (len_i == '0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RD;
          end
        end
      end
      S_RD: begin
        busy    = 1'b1;
        mem_en  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        byte_a_d = mem_a_rdata;
        byte_b_d = mem_b_rdata;
        state_d  = S_MAC;
      end
      S_MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        acc_d  = acc_sum;
        left_d = left_q - 1'b1;
        if (left_q == LEN_W'(1)) begin
          // result captured here so it is valid in the DONE cycle
          result_d = acc_sum;
          state_d  = S_DONE;
        end else if ({1'b0, sub_q} == epb - 4'd1) begin
          sub_d    = '0;
          addr_a_d = addr_a_q + 1'b1;
          addr_b_d = addr_b_q + 1'b1;
          state_d  = S_RD;
        end else begin
          sub_d    = sub_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prec_q   <= PREC_INT8;
      left_q   <= '0;
      sub_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      byte_a_q <= '0;
      byte_b_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      left_q   <= left_d;
      sub_q    <= sub_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      byte_a_q <= byte_a_d;
      byte_b_q <= byte_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result     = result_q;
  assign mem_a_addr = addr_a_q;
  assign mem_b_addr = addr_b_q;
  assign mac_prec   = prec_q;

  mac_operand_unpack u_unpack (
    .en_i      (mac_en),
    .prec_i    (prec_q),
    .sub_idx_i (sub_q),
    .byte_a_i  (byte_a_q),
    .byte_b_i  (byte_b_q),
    .a8_o      (mac_a8),
    .b8_o      (mac_b8),
    .a4_o      (mac_a4),
    .b4_o      (mac_b4),
    .ab_o      (mac_ab),
    .bb_o      (mac_bb)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl with RAM and MAC models.
// A second instance with ACC_W=16 exercises accumulator overflow handling.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start16;
  logic [1:0]  prec_i;
  logic [11:0] len_i;
  logic [9:0]  base_a_i, base_b_i;

  logic        busy, done, mem_en;
  logic [31:0] result;
  logic [9:0]  mem_a_addr, mem_b_addr;
  logic [7:0]  rd_a, rd_b;
  logic [1:0]  mac_prec;
  logic [7:0]  mac_a8, mac_b8;
  logic [3:0]  mac_a4, mac_b4;
  logic        mac_ab, mac_bb;
  logic [31:0] mac_prod;

  logic        busy16, done16, mem_en16;
  logic [15:0] result16;
  logic [9:0]  mem_a_addr16, mem_b_addr16;
  logic [7:0]  rd_a16, rd_b16;
  logic [1:0]  mac_prec16;
  logic [7:0]  mac_a8_16, mac_b8_16;
  logic [3:0]  mac_a4_16, mac_b4_16;
  logic        mac_ab16, mac_bb16;
  logic [31:0] mac_prod16;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.ADDR_W(10), .LEN_W(12), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .prec_i(prec_i), .len_i(len_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i), .busy(busy), .done(done),
    .result(result), .mem_en(mem_en), .mem_a_addr(mem_a_addr),
    .mem_b_addr(mem_b_addr), .mem_a_rdata(rd_a), .mem_b_rdata(rd_b),
    .mac_prec(mac_prec), .mac_a8(mac_a8), .mac_b8(mac_b8), .mac_a4(mac_a4),
    .mac_b4(mac_b4), .mac_ab(mac_ab), .mac_bb(mac_bb), .mac_prod(mac_prod)
  );

  mac_seq_ctrl #(.ADDR_W(10), .LEN_W(12), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .prec_i(prec_i), .len_i(len_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i), .busy(busy16), .done(done16),
    .result(result16), .mem_en(mem_en16), .mem_a_addr(mem_a_addr16),
    .mem_b_addr(mem_b_addr16), .mem_a_rdata(rd_a16), .mem_b_rdata(rd_b16),
    .mac_prec(mac_prec16), .mac_a8(mac_a8_16), .mac_b8(mac_b8_16),
    .mac_a4(mac_a4_16), .mac_b4(mac_b4_16), .mac_ab(mac_ab16),
    .mac_bb(mac_bb16), .mac_prod(mac_prod16)
  );

  // synchronous RAMs: data one cycle after enable
  always_ff @(posedge clk) begin
    if (mem_en) begin
      rd_a <= mem_a[mem_a_addr];
      rd_b <= mem_b[mem_b_addr];
    end
    if (mem_en16) begin
      rd_a16 <= mem_a[mem_a_addr16];
      rd_b16 <= mem_b[mem_b_addr16];
    end
  end

  function automatic logic [31:0] mac_model(input logic [1:0] p,
      input logic [7:0] a8, input logic [7:0] b8, input logic [3:0] a4,
      input logic [3:0] b4, input logic ab, input logic bb);
    logic signed [31:0] x, y;
    case (p)
      2'd0: begin x = 32'(signed'(a8)); y = 32'(signed'(b8)); end
      2'd1: begin x = 32'(signed'(a4)); y = 32'(signed'(b4)); end
      default: begin x = ab ? 32'sd1 : -32'sd1; y = bb ? 32'sd1 : -32'sd1; end
    endcase
    return x * y;
  endfunction

  assign mac_prod   = mac_model(mac_prec, mac_a8, mac_b8, mac_a4, mac_b4, mac_ab, mac_bb);
  assign mac_prod16 = mac_model(mac_prec16, mac_a8_16, mac_b8_16, mac_a4_16, mac_b4_16,
                                mac_ab16, mac_bb16);

  task automatic chk(input string nm, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] prec;
    int         len;
    int         ba;
    int         bb;
    int         exp_res;
    int         exp_lat;
    int         exp_mem;
  } vec_t;

  vec_t vecs [7];

  // Issue one command on the 32-bit instance and watch it to completion.
  // lat=0 means done never arrived within the budget.
  task automatic run_cmd(input vec_t v, output int lat, output int nmem, output int busy_bad);
    @(negedge clk);
    prec_i   = v.prec;
    len_i    = 12'(v.len);
    base_a_i = 10'(v.ba);
    base_b_i = 10'(v.bb);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat = 0; nmem = 0; busy_bad = 0;
    for (int c = 1; c <= 300; c++) begin
      if (mem_en) nmem++;
      if (done) begin
        lat = c;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, nmem, bbad, ndone;

    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    // INT8 [1,-2,3,127] . [5,4,-1,127]
    mem_a[16'h010] = 8'h01; mem_a[16'h011] = 8'hFE; mem_a[16'h012] = 8'h03; mem_a[16'h013] = 8'h7F;
    mem_b[16'h020] = 8'h05; mem_b[16'h021] = 8'h04; mem_b[16'h022] = 8'hFF; mem_b[16'h023] = 8'h7F;
    // INT4
    mem_a[16'h030] = 8'h21; mem_a[16'h031] = 8'h03;
    mem_b[16'h038] = 8'hF2; mem_b[16'h039] = 8'h04;
    // BIN
    mem_a[16'h040] = 8'hFF; mem_b[16'h048] = 8'hFE;
    // address wrap: A at 0x3FF then 0x000
    mem_a[16'h3FF] = 8'h02; mem_a[16'h000] = 8'h03;
    mem_b[16'h200] = 8'h04; mem_b[16'h201] = 8'h05;
    // prec=3 BIN, partial second byte
    mem_a[16'h050] = 8'h00; mem_a[16'h051] = 8'h03;
    mem_b[16'h058] = 8'h00; mem_b[16'h059] = 8'h01;
    // INT4 negative extremes
    mem_a[16'h060] = 8'h88; mem_b[16'h068] = 8'h77;
    // INT8 -128 pairs for the 16-bit accumulator
    mem_a[16'h070] = 8'h80; mem_a[16'h071] = 8'h80;
    mem_b[16'h078] = 8'h80; mem_b[16'h079] = 8'h80;

    vecs[0] = '{"int8_len4",  2'd0,  4, 16'h010, 16'h020, 16123, 13, 4};
    vecs[1] = '{"int4_len3",  2'd1,  3, 16'h030, 16'h038,    12,  8, 2};
    vecs[2] = '{"bin_len8",   2'd2,  8, 16'h040, 16'h048,     6, 11, 1};
    vecs[3] = '{"len0",       2'd0,  0, 16'h010, 16'h020,     0,  1, 0};
    vecs[4] = '{"addr_wrap",  2'd0,  2, 16'h3FF, 16'h200,    23,  7, 2};
    vecs[5] = '{"prec3_len10",2'd3, 10, 16'h050, 16'h058,     8, 15, 2};
    vecs[6] = '{"int4_neg",   2'd1,  2, 16'h060, 16'h068,  -112,  5, 1};

    rst = 1'b1; start = 1'b0; start16 = 1'b0;
    prec_i = '0; len_i = '0; base_a_i = '0; base_b_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_result", result, 0);
    chk("rst_mac_ops", {mac_a8, mac_b8, mac_a4, mac_b4, mac_ab, mac_bb}, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], lat, nmem, bbad);
      chk({vecs[i].name, "_result"},  longint'($signed(result)), vecs[i].exp_res);
      chk({vecs[i].name, "_latency"}, lat,  vecs[i].exp_lat);
      chk({vecs[i].name, "_mem_en"},  nmem, vecs[i].exp_mem);
      chk({vecs[i].name, "_busy"},    bbad, 0);
    end

    // start pulsed during MAC and during DONE must be ignored
    @(negedge clk);
    prec_i = 2'd0; len_i = 12'd4; base_a_i = 10'h010; base_b_i = 10'h020;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      start = (c == 3);
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    chk("busy_start_result", longint'($signed(result)), 16123);
    chk("busy_start_latency", lat, 13);
    start = 1'b1;                  // held through the DONE cycle
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", busy, 0);
    chk("done_start_done", done, 0);

    // reset in the first MAC cycle aborts without a done pulse
    @(negedge clk);
    prec_i = 2'd0; len_i = 12'd4; base_a_i = 10'h010; base_b_i = 10'h020;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);     // now in cycle 3 (MAC)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   busy,   0);
    chk("midrst_result", result, 0);
    chk("midrst_mem_en", mem_en, 0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_done", ndone, 0);
    run_cmd(vecs[0], lat, nmem, bbad);
    chk("after_rst_result",  longint'($signed(result)), 16123);
    chk("after_rst_latency", lat, 13);

    // 16-bit accumulator: 16384 + 16384 overflows
    @(negedge clk);
    prec_i = 2'd0; len_i = 12'd2; base_a_i = 10'h070; base_b_i = 10'h078;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done16) begin lat = c; break; end
      @(negedge clk);
    end
    chk("acc16_latency", lat, 7);
`ifdef MAC_SEQ_SAT_EN
    chk("acc16_sat_result", longint'($signed(result16)), 32767);
`else
    chk("acc16_wrap_result", longint'($signed(result16)), -32768);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
